// File: rtl/sevga_pkg.sv
// Shared SE-VGA video-path types and limits.
package sevga_pkg;

   typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

   localparam int unsigned SER_MAX_WIDTH = 32;

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry valid/ready holding register; drain empties it when the shifter loads.
module piso_hold_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic [WIDTH-1:0] inData,
   input  logic             inValid,
   output logic             inReady,
   input  logic             drain,
   output logic             holdFull,
   output logic [WIDTH-1:0] holdData
);

   logic accept;

   // No accept while full, even on the draining cycle: one ready bubble per word.
   assign inReady = !holdFull;
   assign accept  = inValid && !holdFull;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         holdFull <= 1'b0;
         holdData <= '0;
      end else if (accept) begin
         holdFull <= 1'b1;
         holdData <= inData;
      end else if (drain) begin
         holdFull <= 1'b0;
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Double-buffered PISO pixel serializer for the SE-VGA output path.
// Optional macro PISO_PIXEL_REPEAT_EN: each bit held for two shiftEn strobes.
module piso_serializer
   import sevga_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             shiftEn,
   input  logic [WIDTH-1:0] inData,
   input  logic             inValid,
   output logic             inReady,
   output logic             out,
   output logic             outValid,
   output logic             wordStart,
   output logic             underrun
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_t       state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [WIDTH-1:0] shreg, shregNext;
   logic             underrunNext;
   logic             holdFull, drain, load, step;
   logic [WIDTH-1:0] holdData;
`ifdef PISO_PIXEL_REPEAT_EN
   logic             phase, phaseNext;
`endif

   piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk      (clk),
      .nReset   (nReset),
      .inData   (inData),
      .inValid  (inValid),
      .inReady  (inReady),
      .drain    (drain),
      .holdFull (holdFull),
      .holdData (holdData)
   );

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state    <= SER_IDLE;
         cnt      <= '0;
         shreg    <= '0;
         underrun <= 1'b0;
`ifdef PISO_PIXEL_REPEAT_EN
         phase    <= 1'b0;
`endif
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         shreg    <= shregNext;
         underrun <= underrunNext;
`ifdef PISO_PIXEL_REPEAT_EN
         phase    <= phaseNext;
`endif
      end
   end

   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      shregNext    = shreg;
      underrunNext = 1'b0;
      load         = 1'b0;
`ifdef PISO_PIXEL_REPEAT_EN
      phaseNext    = phase;
      // Bit completes only on the second strobe of its pair.
      step         = shiftEn && phase;
`else
      step         = shiftEn;
`endif

      case (state)
         SER_IDLE: begin
            if (holdFull) load = 1'b1;
         end
         SER_SHIFT: begin
`ifdef PISO_PIXEL_REPEAT_EN
            if (shiftEn) phaseNext = !phase;
`endif
            if (step) begin
               if (cnt == CNT_LAST) begin
                  if (holdFull) begin
                     load = 1'b1;
                  end else begin
                     stateNext    = SER_IDLE;
                     underrunNext = 1'b1;
                  end
               end else begin
                  cntNext   = cnt + CNT_W'(1);
                  shregNext = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
               end
            end
         end
         default: stateNext = SER_IDLE;
      endcase

      if (load) begin
         stateNext = SER_SHIFT;
         cntNext   = '0;
         shregNext = holdData;
`ifdef PISO_PIXEL_REPEAT_EN
         phaseNext = 1'b0;
`endif
      end
      drain = load;
   end

   assign outValid  = (state == SER_SHIFT);
   assign wordStart = (state == SER_SHIFT) && (cnt == '0);
   assign out       = (state == SER_SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                           : IDLE_LEVEL;

endmodule
